// File: rtl/layer_tunnel_renderer.sv
// Layered-plane tunnel pattern generator: LAYERS scaled planes per pixel, priority-encoded
// to a 6-bit colour, animated by a vsync-edge frame counter, two-cycle pixel/sync latency.
module layer_tunnel_renderer #(
    parameter int unsigned LAYERS      = 16,
    parameter int unsigned FRAME_W     = 10,
    parameter int unsigned OFFSET_BITS = 5,
    parameter bit          SYNC_POL    = 1'b0
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic [9:0]         x,
    input  logic [9:0]         y,
    input  logic               video_active,
    input  logic               hsync_in,
    input  logic               vsync_in,
    input  logic [2:0]         speed,
    input  logic               dir,
    input  logic [1:0]         mode,
    input  logic               invert,
    output logic [5:0]         rgb_out,
    output logic               hsync_out,
    output logic               vsync_out,
    output logic [FRAME_W-1:0] frame_cnt
);

    localparam int unsigned LOG2L     = $clog2(LAYERS);
    localparam int unsigned STEP      = 256 / LAYERS;
    localparam int unsigned COL_SH    = 6 - LOG2L;
    localparam logic        SYNC_IDLE = ~SYNC_POL;

    logic               vsync_q;
    logic [FRAME_W-1:0] frame_cnt_q, frame_cnt_d;
    logic [1:0]         mode_l_q;
    logic               inv_l_q;
    logic [LAYERS-1:0]  hit_s1_q, hit_c;
    logic               active_s1_q, inv_s1_q, hs_s1_q, vs_s1_q;
    logic [5:0]         rgb_q, rgb_d;
    logic               hs_q, vs_q;
    logic               tick_c;

    logic [OFFSET_BITS-1:0] off_c;
    logic signed [11:0]     xs_c;
    logic [7:0]             d_c;
    logic [8:0]             mask_c, xsi_c, ysi_c;
    logic [LOG2L-1:0]       idx_c;
    logic [5:0]             col_c;

    // First cycle of a sync pulse; vsync is only ever sampled, never used as a clock.
    assign tick_c      = (vsync_in == SYNC_POL) && (vsync_q != SYNC_POL);
    assign frame_cnt_d = dir ? frame_cnt_q - FRAME_W'(speed) : frame_cnt_q + FRAME_W'(speed);

    assign off_c = frame_cnt_q[OFFSET_BITS-1:0];
    assign xs_c  = 12'(x) + 12'(off_c) - 12'd320;

    // Per-layer plane hit test; bit i is plane i, higher index drawn on top.
    always_comb begin
        hit_c  = '0;
        d_c    = '0;
        mask_c = '0;
        xsi_c  = '0;
        ysi_c  = '0;
        for (int i = 0; i < LAYERS; i++) begin
            d_c    = 8'(255 - i * STEP);
            mask_c = 9'(i << (9 - LOG2L));
            xsi_c  = 9'((20'(xs_c) * $signed(20'(d_c))) >>> 6);
            ysi_c  = 9'((18'(y) * 18'(d_c)) >> 6);
            case (mode_l_q)
                2'd0:    hit_c[i] = ((ysi_c & mask_c) == 9'd0) && (xsi_c[7:5] == 3'd0);
                2'd1:    hit_c[i] = xsi_c[5] ^ ysi_c[5] ^ 1'(i);
                2'd2:    hit_c[i] = (xsi_c & ysi_c & mask_c) == 9'd0;
                default: hit_c[i] = xsi_c[7:5] == 3'd0;
            endcase
        end
    end

    // Highest set hit bit wins; an empty vector falls through to index 0.
    always_comb begin
        idx_c = '0;
        for (int i = 0; i < LAYERS; i++) begin
            if (hit_s1_q[i]) begin
                idx_c = LOG2L'(i);
            end
        end
        col_c = 6'(idx_c) << COL_SH;
        rgb_d = active_s1_q ? (inv_s1_q ? ~col_c : col_c) : 6'd0;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            vsync_q     <= SYNC_IDLE;
            frame_cnt_q <= '0;
            mode_l_q    <= '0;
            inv_l_q     <= 1'b0;
            hit_s1_q    <= '0;
            active_s1_q <= 1'b0;
            inv_s1_q    <= 1'b0;
            hs_s1_q     <= SYNC_IDLE;
            vs_s1_q     <= SYNC_IDLE;
            rgb_q       <= '0;
            hs_q        <= SYNC_IDLE;
            vs_q        <= SYNC_IDLE;
        end else begin
            vsync_q <= vsync_in;
            if (tick_c) begin
                frame_cnt_q <= frame_cnt_d;
                mode_l_q    <= mode;
                inv_l_q     <= invert;
            end
            // Inversion travels with the pixel so a tick never splits one pixel's settings.
            hit_s1_q    <= hit_c;
            active_s1_q <= video_active;
            inv_s1_q    <= inv_l_q;
            hs_s1_q     <= hsync_in;
            vs_s1_q     <= vsync_in;
            rgb_q       <= rgb_d;
            hs_q        <= hs_s1_q;
            vs_q        <= vs_s1_q;
        end
    end

    assign rgb_out   = rgb_q;
    assign hsync_out = hs_q;
    assign vsync_out = vs_q;
    assign frame_cnt = frame_cnt_q;

endmodule
